cnn_layer_sequencer: RTL

- Top-level layer controller for the CNN accelerator.
- Launches the layer engines in fixed order, one at a time: conv L1, maxpool-ReLU L1, conv L2, maxpool-ReLU L2.
- Each engine gets a single-cycle run pulse; the sequencer then waits for that engine's done pulse.
- Drives the ping-pong M10K bank select so each layer reads the previous layer's output bank; raises a completion pulse when all enabled layers have finished.

---
 rtl/cnn_ctrl_pkg.sv | 23 ++
 rtl/next_enabled_stage.sv | 33 +++
 rtl/cnn_layer_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the CNN layer controller: sequencer state encoding,
// fixed stage order of the layer engines and ping-pong M10K bank encoding.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FINISH = 3'd3,
    ERROR  = 3'd4
  } seq_state_t;

  // Engine launch order
  localparam int unsigned STAGE_CONV1 = 0;
  localparam int unsigned STAGE_POOL1 = 1;
  localparam int unsigned STAGE_CONV2 = 2;
  localparam int unsigned STAGE_POOL2 = 3;

  // Source bank select; the active engine writes the opposite bank
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage : cnn_ctrl_pkg

// File: rtl/next_enabled_stage.sv
// Combinational priority search for the next enabled stage.
// Ports:
//   en         - per-stage enable mask
//   cur_idx    - index of the current stage
//   from_start - treat the start index as -1 (search includes stage 0)
//   next_idx_c - lowest enabled index above the start point
//   found_c    - an enabled stage exists above the start point
module next_enabled_stage
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  localparam int unsigned IDX_W = $clog2(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] en,
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic                  from_start,
  output logic [IDX_W-1:0]      next_idx_c,
  output logic                  found_c
);

  // Ascending scan; the first hit wins so the lowest qualifying index is taken
  always_comb begin
    next_idx_c = '0;
    found_c    = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!found_c && en[i] && (from_start || (IDX_W'(i) > cur_idx))) begin
        found_c    = 1'b1;
        next_idx_c = IDX_W'(i);
      end
    end
  end

endmodule : next_enabled_stage

// File: rtl/cnn_layer_sequencer.sv
// Top-level layer controller: launches the enabled layer engines one at a time
// in index order, waits for each engine's done pulse, steers the ping-pong
// bank select and pulses all_done_out when the sequence completes.
// Optional watchdog: define CNN_SEQ_WATCHDOG_EN to time out a stalled stage.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   start            - begin a sequence (accepted only in IDLE)
//   abort_in         - cancel from any state (highest priority)
//   stage_enable_in  - per-stage enable, latched on accepted start
//   stage_done_in    - done pulses from the engines
//   stage_run_out    - one-hot single-cycle run pulse
//   stage_idx_out    - active stage index
//   bank_sel_out     - source bank of the active stage
//   busy_out         - sequence in progress
//   all_done_out     - single-cycle completion pulse
//   error_out        - watchdog timeout flag
module cnn_layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  localparam int unsigned IDX_W = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort_in,
  input  logic [NUM_STAGES-1:0] stage_enable_in,
  input  logic [NUM_STAGES-1:0] stage_done_in,
  output logic [NUM_STAGES-1:0] stage_run_out,
  output logic [IDX_W-1:0]      stage_idx_out,
  output logic                  bank_sel_out,
  output logic                  busy_out,
  output logic                  all_done_out,
  output logic                  error_out
);

  seq_state_t state_q, state_d;

  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  bank_q, bank_d;
  logic [NUM_STAGES-1:0] run_q, run_d;
  logic                  busy_q, busy_d;
  logic                  all_done_q, all_done_d;

  logic [IDX_W-1:0] first_idx_c, nxt_idx_c;
  logic             first_found_c, nxt_found_c;
  logic             done_sel_c;
  logic             wd_expire_c;

  // Only the active stage's done is observed
  assign done_sel_c = stage_done_in[idx_q];

  // First stage of a new sequence, searched on the raw enable being latched
  next_enabled_stage #(.NUM_STAGES(NUM_STAGES)) u_first (
    .en         (stage_enable_in),
    .cur_idx    ('0),
    .from_start (1'b1),
    .next_idx_c (first_idx_c),
    .found_c    (first_found_c)
  );

  // Next enabled stage above the active one
  next_enabled_stage #(.NUM_STAGES(NUM_STAGES)) u_next (
    .en         (en_q),
    .cur_idx    (idx_q),
    .from_start (1'b0),
    .next_idx_c (nxt_idx_c),
    .found_c    (nxt_found_c)
  );

`ifdef CNN_SEQ_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             error_q;

  // Counter is zero during the run cycle, so expiry lands TIMEOUT_CYCLES after run
  assign wd_expire_c = (state_q == WAIT) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (state_d == LAUNCH) begin
      wd_cnt_q <= '0;
    end else if ((state_q == LAUNCH) || (state_q == WAIT)) begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  // Error flag mirrors residence in ERROR
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state_d == ERROR);
    end
  end

  assign error_out = error_q;
`else
  logic unused_timeout;

  assign wd_expire_c    = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign error_out      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_d = state_q;
    if (abort_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = first_found_c ? LAUNCH : FINISH;
          end
        end
        LAUNCH: state_d = WAIT;
        WAIT: begin
          if (done_sel_c) begin
            state_d = nxt_found_c ? LAUNCH : FINISH;
          end else if (wd_expire_c) begin
            state_d = ERROR;
          end
        end
        FINISH:  state_d = IDLE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    en_d       = en_q;
    idx_d      = idx_q;
    bank_d     = bank_q;
    run_d      = '0;
    all_done_d = 1'b0;
    // busy stays up for one trailing cycle after FINISH unless aborted
    busy_d     = (state_d != IDLE) || ((state_q == FINISH) && !abort_in);
    if (!abort_in) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            en_d   = stage_enable_in;
            bank_d = BANK_A;
            if (first_found_c) begin
              idx_d = first_idx_c;
              run_d = NUM_STAGES'(1) << first_idx_c;
            end else begin
              all_done_d = 1'b1;
            end
          end
        end
        WAIT: begin
          if (done_sel_c) begin
            bank_d = ~bank_q;
            if (nxt_found_c) begin
              idx_d = nxt_idx_c;
              run_d = NUM_STAGES'(1) << nxt_idx_c;
            end else begin
              all_done_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output and enable registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= '0;
      idx_q      <= '0;
      bank_q     <= 1'b0;
      run_q      <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      en_q       <= en_d;
      idx_q      <= idx_d;
      bank_q     <= bank_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
    end
  end

  assign stage_run_out = run_q;
  assign stage_idx_out = idx_q;
  assign bank_sel_out  = bank_q;
  assign busy_out      = busy_q;
  assign all_done_out  = all_done_q;

endmodule : cnn_layer_sequencer
